// File: rtl/lns_pipe_slice.sv
// Elastic valid/ready pipeline for the LNS FMA datapath: DEPTH skid-buffered slices, registered in_ready.
// Optional LNS_PIPE_STATS_EN adds saturating stall_count / drop_count outputs.
//
// Per-slice state (encoded by main/skid valid bits):
//   state | meaning
//   EMPTY | main invalid, upstream ready
//   HALF  | main valid, skid invalid, upstream ready
//   FULL  | main and skid valid, upstream stalled
module lns_pipe_slice #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
`ifdef LNS_PIPE_STATS_EN
  ,
  output logic [31:0]      stall_count,
  output logic [15:0]      drop_count
`endif
);

  logic [DEPTH-1:0] main_valid;
  logic [DEPTH-1:0] up_ready;
  logic [DEPTH-1:0] up_valid;
  logic [DEPTH-1:0] down_ready;
  logic [WIDTH-1:0] main_data [DEPTH];
  logic [WIDTH-1:0] up_data   [DEPTH];

  logic in_xfer;
  logic out_xfer;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_slice
      logic             m_v;
      logic             s_v;
      logic             rdy;
      logic [WIDTH-1:0] m_d;
      logic [WIDTH-1:0] s_d;
      logic             push;
      logic             pop;

      if (i == 0) begin : g_head
        assign up_valid[i] = in_valid;
        assign up_data[i]  = in_data;
      end else begin : g_link
        assign up_valid[i] = main_valid[i-1];
        assign up_data[i]  = main_data[i-1];
      end

      if (i == DEPTH-1) begin : g_tail
        assign down_ready[i] = out_ready;
      end else begin : g_next
        assign down_ready[i] = up_ready[i+1];
      end

      assign push = up_valid[i] & rdy;
      assign pop  = m_v & down_ready[i];

      // rdy tracks the next value of NOT s_v so no combinational ready path exists
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          m_v <= 1'b0;
          s_v <= 1'b0;
          rdy <= 1'b0;
          m_d <= '0;
          s_d <= '0;
        end else if (flush) begin
          m_v <= 1'b0;
          s_v <= 1'b0;
          rdy <= 1'b1;
        end else begin
          rdy <= ~s_v;
          if (pop) begin
            if (s_v) begin
              m_d <= s_d;
              s_v <= 1'b0;
              rdy <= 1'b1;
            end else if (push) begin
              m_d <= up_data[i];
            end else begin
              m_v <= 1'b0;
            end
          end else if (push) begin
            if (m_v) begin
              s_d <= up_data[i];
              s_v <= 1'b1;
              rdy <= 1'b0;
            end else begin
              m_d <= up_data[i];
              m_v <= 1'b1;
            end
          end
        end
      end

      assign main_valid[i] = m_v;
      assign main_data[i]  = m_d;
      assign up_ready[i]   = rdy;
    end
  endgenerate

  assign in_ready  = up_ready[0];
  assign out_valid = main_valid[DEPTH-1];
  assign out_data  = main_data[DEPTH-1];

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + CNT_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occupancy <= occupancy - CNT_W'(1);
    end
  end

`ifdef LNS_PIPE_STATS_EN
  logic [16:0] drop_sum;

  // out_xfer implies occupancy >= 1, so the subtraction cannot wrap
  assign drop_sum = {1'b0, drop_count} + 17'(occupancy) + 17'(in_xfer) - 17'(out_xfer);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && !(&stall_count)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (flush) begin
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule
